// File: rtl/ysyx_24090003_lsu_pkg.sv
// Shared encodings for the load/store unit: access widths, FSM states and
// the alignment rule used both at request acceptance and in lane steering.
package ysyx_24090003_lsu_pkg;

    localparam logic [1:0] MEM_W_BYTE = 2'b00;
    localparam logic [1:0] MEM_W_HALF = 2'b01;
    localparam logic [1:0] MEM_W_WORD = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_RESP = 2'd3
    } lsu_state_t;

    // Width code 2'b11 falls into the word rule.
    function automatic logic lsu_misaligned(input logic [1:0] width, input logic [1:0] offset);
        logic mis;
        case (width)
            MEM_W_BYTE: mis = 1'b0;
            MEM_W_HALF: mis = offset[0];
            default:    mis = (offset != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ysyx_24090003_lsu_align.sv
// Combinational lane logic: store data replication and write strobes,
// misalign detection, and load shift with sign/zero extension.
module ysyx_24090003_lsu_align
    import ysyx_24090003_lsu_pkg::*;
(
    input  logic [1:0]  i_width,
    input  logic [1:0]  i_offset,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wmask,
    output logic        o_misalign,
    output logic [31:0] o_ldata
);

    logic [31:0] w_shift;
    logic        w_sign;

    always_comb begin
        o_wdata    = i_wdata;
        o_wmask    = 4'b1111;
        o_misalign = lsu_misaligned(i_width, i_offset);
        case (i_width)
            MEM_W_BYTE: begin
                o_wdata = {4{i_wdata[7:0]}};
                o_wmask = 4'b0001 << i_offset;
            end
            MEM_W_HALF: begin
                o_wdata = {2{i_wdata[15:0]}};
                o_wmask = 4'b0011 << {i_offset[1], 1'b0};
            end
            default: begin
                o_wdata = i_wdata;
                o_wmask = 4'b1111;
            end
        endcase
    end

    // The bus returns the whole word; move the addressed lane down to bit 0.
    always_comb begin
        w_shift = i_rdata >> {i_offset, 3'b000};
        w_sign  = 1'b0;
        o_ldata = w_shift;
        case (i_width)
            MEM_W_BYTE: begin
                w_sign  = ~i_unsigned & w_shift[7];
                o_ldata = {{24{w_sign}}, w_shift[7:0]};
            end
            MEM_W_HALF: begin
                w_sign  = ~i_unsigned & w_shift[15];
                o_ldata = {{16{w_sign}}, w_shift[15:0]};
            end
            default: begin
                o_ldata = w_shift;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_24090003_lsu.sv
// Load/store unit between EXU and WBU: one request in flight, word-addressed
// req/gnt/rvalid bus, all outputs decoded from registered state.
module ysyx_24090003_lsu
    import ysyx_24090003_lsu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_mem_en,
    input  logic        i_mem_we,
    input  logic [1:0]  i_mem_width,
    input  logic        i_mem_unsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_rdata,
    output logic        o_misalign,
    output logic        o_bus_err,
    output logic        o_bus_req,
    input  logic        i_bus_gnt,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_wmask,
    input  logic        i_bus_rvalid,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_err
);

    lsu_state_t  r_state;
    lsu_state_t  w_state_next;

    logic        r_en;
    logic        r_we;
    logic [1:0]  r_width;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_capture;
    logic [31:0] w_lane_wdata;
    logic [3:0]  w_lane_wmask;
    logic        w_misalign;
    logic [31:0] w_ldata;

    ysyx_24090003_lsu_align u_align (
        .i_width    (r_width),
        .i_offset   (r_addr[1:0]),
        .i_unsigned (r_unsigned),
        .i_wdata    (r_wdata),
        .i_rdata    (r_rdata),
        .o_wdata    (w_lane_wdata),
        .o_wmask    (w_lane_wmask),
        .o_misalign (w_misalign),
        .o_ldata    (w_ldata)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= LSU_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        o_ready      = 1'b0;
        o_valid      = 1'b0;
        o_bus_req    = 1'b0;
        case (r_state)
            LSU_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    w_accept = 1'b1;
                    // Bubbles and misaligned accesses never touch the bus.
                    if (!i_mem_en || lsu_misaligned(i_mem_width, i_addr[1:0])) begin
                        w_state_next = LSU_RESP;
                    end else begin
                        w_state_next = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                o_bus_req = 1'b1;
                if (i_bus_gnt) begin
                    if (i_bus_rvalid) begin
                        w_capture    = 1'b1;
                        w_state_next = LSU_RESP;
                    end else begin
                        w_state_next = LSU_WAIT;
                    end
                end
            end
            LSU_WAIT: begin
                if (i_bus_rvalid) begin
                    w_capture    = 1'b1;
                    w_state_next = LSU_RESP;
                end
            end
            LSU_RESP: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    w_state_next = LSU_IDLE;
                end
            end
            default: begin
                w_state_next = LSU_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_en       <= 1'b0;
            r_we       <= 1'b0;
            r_width    <= MEM_W_BYTE;
            r_unsigned <= 1'b0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_rdata    <= 32'h0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_en       <= i_mem_en;
            r_we       <= i_mem_we;
            r_width    <= i_mem_width;
            r_unsigned <= i_mem_unsigned;
            r_addr     <= i_addr;
            r_wdata    <= i_wdata;
            r_rdata    <= 32'h0;
            r_err      <= 1'b0;
        end else if (w_capture) begin
            r_rdata    <= i_bus_rdata;
            r_err      <= i_bus_err;
        end
    end

    // Bus and result fields are gated by state so they read zero when idle.
    always_comb begin
        o_bus_we    = (r_state == LSU_REQ) & r_we;
        o_bus_addr  = (r_state == LSU_REQ) ? {r_addr[31:2], 2'b00} : 32'h0;
        o_bus_wdata = (r_state == LSU_REQ) ? w_lane_wdata : 32'h0;
        o_bus_wmask = (r_state == LSU_REQ && r_we) ? w_lane_wmask : 4'b0000;
        o_misalign  = (r_state == LSU_RESP) & r_en & w_misalign;
        o_bus_err   = (r_state == LSU_RESP) & r_err;
        o_rdata     = (r_state == LSU_RESP && r_en && !r_we && !r_err && !w_misalign)
                      ? w_ldata : 32'h0;
    end

endmodule
